// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the MAR side (master) and the memory responder (slave).
// Request fields are qualified by MEM_req; response fields are qualified by MEM_ack.
// MEM_busy tells the master when a new request will not be sampled.
interface mem_ctrl_if;
  logic        MEM_req;
  logic        MEM_we;
  logic [15:0] MEM_addr;
  logic [15:0] MEM_wdata;
  logic [15:0] MEM_rdata;
  logic        MEM_ack;
  logic        MEM_err;
  logic        MEM_busy;

  modport master (
    output MEM_req,
    output MEM_we,
    output MEM_addr,
    output MEM_wdata,
    input  MEM_rdata,
    input  MEM_ack,
    input  MEM_err,
    input  MEM_busy
  );

  modport slave (
    input  MEM_req,
    input  MEM_we,
    input  MEM_addr,
    input  MEM_wdata,
    output MEM_rdata,
    output MEM_ack,
    output MEM_err,
    output MEM_busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory responder: one read/write at a time on an internal word-addressed RAM, with range check.
// Latency: MEM_ack in the (WAIT_CYCLES+1)th cycle after the request edge; one access per WAIT_CYCLES+2 cycles.
// Backpressure: MEM_req is only sampled in IDLE; MEM_busy marks the cycles where it is ignored.
module mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic      MEM_clk,
  input  logic      MEM_rst,
  mem_ctrl_if.slave mem
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam int         WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_LOAD);
  localparam int         DEPTH     = 1 << ADDR_W;

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [15:0]       lat_addr;
  logic [15:0]       lat_wdata;
  logic [15:0]       rdata_q;
  logic              err_q;

  logic [15:0]       ram [DEPTH];

  logic              do_access;
  logic              acc_we;
  logic [15:0]       acc_addr;
  logic [15:0]       acc_wdata;
  logic              acc_in_range;
  logic [ADDR_W-1:0] acc_idx;

  // Pick the fields used on the access edge: live inputs when accessing straight out of IDLE
  // (zero wait states), otherwise the copies latched at the request edge.
  always_comb begin
    do_access = 1'b0;
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      acc_we    = mem.MEM_we;
      acc_addr  = mem.MEM_addr;
      acc_wdata = mem.MEM_wdata;
      do_access = mem.MEM_req && (WAIT_CYCLES == 0);
    end else if (state == ST_WAIT) begin
      do_access = (wait_cnt == 4'd0);
    end
  end

  // Address is in range only when every bit above the implemented width is zero.
  assign acc_in_range = ((acc_addr >> ADDR_W) == 16'd0);
  assign acc_idx      = acc_addr[ADDR_W-1:0];

  // Control FSM, request latch and response registers; reset abandons any pending access.
  always_ff @(posedge MEM_clk) begin
    if (MEM_rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      rdata_q   <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem.MEM_req) begin
            lat_we    <= mem.MEM_we;
            lat_addr  <= mem.MEM_addr;
            lat_wdata <= mem.MEM_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ST_ACK;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (do_access) begin
        if (!acc_in_range) begin
          rdata_q <= 16'h0000;
          err_q   <= 1'b1;
        end else begin
          err_q <= 1'b0;
          if (!acc_we) begin
            rdata_q <= ram[acc_idx];
          end
        end
      end
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge MEM_clk) begin
    if (!MEM_rst && do_access && acc_we && acc_in_range) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

  // Outputs decode from registered state only, so there is no input-to-output path.
  assign mem.MEM_ack   = (state == ST_ACK);
  assign mem.MEM_busy  = (state != ST_IDLE);
  assign mem.MEM_rdata = rdata_q;
  assign mem.MEM_err   = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a WAIT_CYCLES=2 build and a WAIT_CYCLES=0 build share one stimulus stream.
// A transaction-countdown model checks both DUTs every cycle; directed literals pin the model.
// Summary line reports passed/total comparisons.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_ctrl_if bus0 ();
  mem_ctrl_if bus1 ();

  assign bus0.MEM_req   = req;
  assign bus0.MEM_we    = we;
  assign bus0.MEM_addr  = addr;
  assign bus0.MEM_wdata = wdata;
  assign bus1.MEM_req   = req;
  assign bus1.MEM_we    = we;
  assign bus1.MEM_addr  = addr;
  assign bus1.MEM_wdata = wdata;

  mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(2)) dut0 (.MEM_clk(clk), .MEM_rst(rst), .mem(bus0));
  mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) dut1 (.MEM_clk(clk), .MEM_rst(rst), .mem(bus1));

  logic        dut_ack  [2];
  logic        dut_busy [2];
  logic        dut_err  [2];
  logic [15:0] dut_rd   [2];
  assign dut_ack[0]  = bus0.MEM_ack;
  assign dut_ack[1]  = bus1.MEM_ack;
  assign dut_busy[0] = bus0.MEM_busy;
  assign dut_busy[1] = bus1.MEM_busy;
  assign dut_err[0]  = bus0.MEM_err;
  assign dut_err[1]  = bus1.MEM_err;
  assign dut_rd[0]   = bus0.MEM_rdata;
  assign dut_rd[1]   = bus1.MEM_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each DUT is a countdown of edges until the transaction retires: after the request edge
  // it holds WAIT_CYCLES+1; the access happens on the edge that leaves it at 1 (the ack cycle).
  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  bit          model_ok = 1'b0;
  int          mcnt     [2];
  logic        mwe      [2];
  logic [15:0] maddr    [2];
  logic [15:0] mwdata   [2];
  logic [15:0] mrd      [2];
  bit          mrd_known[2];
  logic        merr     [2];
  logic [15:0] mmem     [2][256];
  bit          mknown   [2][256];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mcnt[d]      = 0;
        mrd[d]       = 16'h0000;
        mrd_known[d] = 1'b1;
        merr[d]      = 1'b0;
      end else begin
        if (mcnt[d] > 0) begin
          mcnt[d] = mcnt[d] - 1;
        end else if (req) begin
          mwe[d]    = we;
          maddr[d]  = addr;
          mwdata[d] = wdata;
          mcnt[d]   = wc(d) + 1;
        end
        if (mcnt[d] == 1) begin
          if (maddr[d] < 16'd256) begin
            merr[d] = 1'b0;
            if (mwe[d]) begin
              mmem[d][maddr[d][7:0]]   = mwdata[d];
              mknown[d][maddr[d][7:0]] = 1'b1;
            end else begin
              mrd[d]       = mmem[d][maddr[d][7:0]];
              mrd_known[d] = mknown[d][maddr[d][7:0]];
            end
          end else begin
            mrd[d]       = 16'h0000;
            mrd_known[d] = 1'b1;
            merr[d]      = 1'b1;
          end
        end
      end
    end
    if (rst) model_ok = 1'b1;
  end

  // Compare both DUTs against the model mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d_ack", d), 32'(dut_ack[d]), 32'(mcnt[d] == 1));
        check($sformatf("dut%0d_busy", d), 32'(dut_busy[d]), 32'(mcnt[d] >= 1));
        check($sformatf("dut%0d_err", d), 32'(dut_err[d]), 32'(merr[d]));
        if (mrd_known[d]) begin
          check($sformatf("dut%0d_rdata", d), 32'(dut_rd[d]), 32'(mrd[d]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic [15:0] a, input logic [15:0] dat);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = dat;
  endtask

  // Runs 8 cycles from the request edge, recording the first ack of each DUT (cycle index
  // counted from 1 = the cycle right after the request edge).
  task automatic run_txn(input bit churn, output int lat0, output int lat1,
                         output logic [15:0] rd0, output logic [15:0] rd1, output logic e0);
    lat0 = -1;
    lat1 = -1;
    rd0  = 16'h0000;
    rd1  = 16'h0000;
    e0   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) req = 1'b0;
      if (bus0.MEM_ack && lat0 < 0) begin
        lat0 = k;
        rd0  = bus0.MEM_rdata;
        e0   = bus0.MEM_err;
      end
      if (bus1.MEM_ack && lat1 < 0) begin
        lat1 = k;
        rd1  = bus1.MEM_rdata;
      end
      if (churn) begin
        we    = 1'($urandom);
        addr  = 16'($urandom);
        wdata = 16'($urandom);
      end
    end
  endtask

  initial begin
    int          lat0, lat1, n, prev, cyc, acks;
    logic [15:0] rd0, rd1;
    logic        e0;

    // Reset held two edges with a request pending: nothing may start.
    rst = 1'b1;
    start(1'b1, 16'h0012, 16'hBEEF);
    tick();
    tick();
    check("rst_ack", 32'(bus0.MEM_ack), 32'd0);
    check("rst_busy", 32'(bus0.MEM_busy), 32'd0);
    check("rst_err", 32'(bus0.MEM_err), 32'd0);
    check("rst_rdata", 32'(bus0.MEM_rdata), 32'h0000);
    check("rst_busy_w0", 32'(bus1.MEM_busy), 32'd0);

    // Release reset: the held request is the BEEF write to 0x0012.
    rst = 1'b0;
    run_txn(1'b0, lat0, lat1, rd0, rd1, e0);
    check("wr_beef_lat", 32'(lat0), 32'd3);
    check("wr_beef_lat_w0", 32'(lat1), 32'd1);
    check("wr_beef_err", 32'(e0), 32'd0);

    // Read it back while the inputs churn every cycle after the request edge.
    start(1'b0, 16'h0012, 16'h0000);
    run_txn(1'b1, lat0, lat1, rd0, rd1, e0);
    check("rd_beef_lat", 32'(lat0), 32'd3);
    check("rd_beef_data", 32'(rd0), 32'hBEEF);
    check("rd_beef_data_w0", 32'(rd1), 32'hBEEF);
    check("rd_beef_err", 32'(e0), 32'd0);

    // Back-to-back with MEM_req held: write i+1 to i (i=0..3), then read 0..3.
    start(1'b1, 16'h0000, 16'h0001);
    n    = 0;
    prev = -1;
    cyc  = 0;
    while (n < 8 && cyc < 60) begin
      tick();
      cyc++;
      if (bus0.MEM_ack) begin
        if (prev >= 0) check($sformatf("b2b_spacing_%0d", n), 32'(cyc - prev), 32'd4);
        if (n >= 4) check($sformatf("b2b_rd_%0d", n - 4), 32'(bus0.MEM_rdata), 32'(n - 3));
        prev = cyc;
        n++;
        if (n < 8) begin
          we    = (n < 4);
          addr  = 16'(n % 4);
          wdata = 16'(n + 1);
        end else begin
          req = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(n), 32'd8);
    req = 1'b0;
    tick();
    tick();
    tick();

    // Out-of-range write must flag an error and leave RAM[0] untouched.
    start(1'b1, 16'h0100, 16'h1234);
    run_txn(1'b0, lat0, lat1, rd0, rd1, e0);
    check("oor_lat", 32'(lat0), 32'd3);
    check("oor_err", 32'(e0), 32'd1);
    check("oor_rdata", 32'(rd0), 32'h0000);
    start(1'b0, 16'h0000, 16'h0000);
    run_txn(1'b0, lat0, lat1, rd0, rd1, e0);
    check("after_oor_data", 32'(rd0), 32'h0001);
    check("after_oor_err", 32'(e0), 32'd0);

    // Reset in the first wait cycle abandons the write (the zero-wait build already wrote it).
    start(1'b1, 16'h0005, 16'h5555);
    run_txn(1'b0, lat0, lat1, rd0, rd1, e0);
    start(1'b1, 16'h0005, 16'hAAAA);
    tick();
    req = 1'b0;
    check("mid_busy_before_rst", 32'(bus0.MEM_busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_ack", 32'(bus0.MEM_ack), 32'd0);
    check("mid_rst_busy", 32'(bus0.MEM_busy), 32'd0);
    rst  = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus0.MEM_ack) acks++;
    end
    check("mid_rst_no_ack", 32'(acks), 32'd0);
    start(1'b0, 16'h0005, 16'h0000);
    run_txn(1'b0, lat0, lat1, rd0, rd1, e0);
    check("mid_rst_rd", 32'(rd0), 32'h5555);
    check("mid_rst_rd_w0", 32'(rd1), 32'hAAAA);
    check("mid_rst_lat_w0", 32'(lat1), 32'd1);

    tick();
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
